// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module  : aes_pkg
// Brief   : Shared types and constants for the AES-128 round sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package aes_pkg;

    typedef logic [127:0] block_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        INIT     = 3'd1,
        SUB_REQ  = 3'd2,
        SUB_WAIT = 3'd3,
        MIX      = 3'd4,
        DONE     = 3'd5
    } aes_ctrl_state_t;

    localparam int AES_ROUNDS = 10;

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1B, 8'h36
    };

    // Rounds outside 1..10 have no round constant.
    function automatic logic [7:0] rcon_lookup(input logic [3:0] r);
        logic [7:0] v;
        v = 8'h00;
        if ((r >= 4'd1) && (r <= 4'(AES_ROUNDS))) begin
            v = RCON[r];
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_round_cnt.sv
`default_nettype none
// ============================================================================
// Module  : aes_round_cnt
// Brief   : AES round counter (0..10) with round-constant lookup.
// Revision: 1.0 - initial release
// ============================================================================
module aes_round_cnt
    import aes_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clear_i,
    input  logic       load_i,
    input  logic       inc_i,
    input  logic       rcon_en_i,
    output logic [3:0] round_o,
    output logic [7:0] rcon_o,
    output logic       last_o
);

    logic [3:0] round_q;
    logic [3:0] round_d;

    // Clear has priority; the counter saturates at the final round.
    always_comb begin
        round_d = round_q;
        if (clear_i) begin
            round_d = 4'd0;
        end else if (load_i) begin
            round_d = 4'd1;
        end else if (inc_i && (round_q < 4'(AES_ROUNDS))) begin
            round_d = round_q + 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            round_q <= 4'd0;
        end else begin
            round_q <= round_d;
        end
    end

    assign round_o = round_q;
    assign last_o  = (round_q == 4'(AES_ROUNDS));
    assign rcon_o  = rcon_en_i ? rcon_lookup(round_q) : 8'h00;

endmodule
`default_nettype wire

// File: rtl/aes_round_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : aes_round_ctrl
// Brief   : AES-128 round sequencer driving a shared SubBytes/ShiftRows/
//           MixColumns/key-expansion datapath, with SubBytes watchdog.
// Revision: 1.0 - initial release
// ============================================================================
module aes_round_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned SB_MAX_WAIT = 15
) (
    input  logic         int_osc,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         sb_start,
    output logic [127:0] sb_in,
    input  logic         sb_done,
    input  logic [127:0] sb_out,
    output logic [127:0] sr_in,
    input  logic [127:0] sr_out,
    input  logic [127:0] mc_out,
    output logic [127:0] key_cur,
    output logic [7:0]   rcon,
    input  logic [127:0] key_next,
    output logic [127:0] sreg,
    output logic [3:0]   round,
    output logic         busy,
    output logic         done,
    output logic         alarm,
    output logic [127:0] cyphertext
);

    localparam int WAIT_W = (SB_MAX_WAIT < 2) ? 1 : $clog2(SB_MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SB_MAX_WAIT - 1);

    aes_ctrl_state_t state_q, state_d;
    block_t          pt_q, pt_d;
    block_t          kin_q, kin_d;
    block_t          sreg_q, sreg_d;
    block_t          key_q, key_d;
    block_t          srin_q, srin_d;
    block_t          ct_q, ct_d;
    logic            alarm_q, alarm_d;
    logic [WAIT_W-1:0] wait_q, wait_d;

    logic   cnt_clear;
    logic   cnt_load;
    logic   cnt_inc;
    logic   last_round;
    logic   active;
    block_t mix_val;

    assign active  = (state_q != IDLE) && (state_q != DONE);
    // The final round skips MixColumns.
    assign mix_val = (last_round ? sr_out : mc_out) ^ key_next;

    aes_round_cnt u_round_cnt (
        .clk_i     (int_osc),
        .rst_i     (reset),
        .clear_i   (cnt_clear),
        .load_i    (cnt_load),
        .inc_i     (cnt_inc),
        .rcon_en_i (active),
        .round_o   (round),
        .rcon_o    (rcon),
        .last_o    (last_round)
    );

    always_comb begin
        state_d   = state_q;
        pt_d      = pt_q;
        kin_d     = kin_q;
        sreg_d    = sreg_q;
        key_d     = key_q;
        srin_d    = srin_q;
        ct_d      = ct_q;
        alarm_d   = alarm_q;
        wait_d    = wait_q;
        cnt_clear = 1'b0;
        cnt_load  = 1'b0;
        cnt_inc   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    pt_d    = plaintext;
                    kin_d   = key;
                    state_d = INIT;
                end
            end
            INIT: begin
                sreg_d   = pt_q ^ kin_q;
                key_d    = kin_q;
                cnt_load = 1'b1;
                state_d  = SUB_REQ;
            end
            SUB_REQ: begin
                wait_d  = '0;
                state_d = SUB_WAIT;
            end
            SUB_WAIT: begin
                if (sb_done) begin
                    srin_d  = sb_out;
                    state_d = MIX;
                end else if (wait_q == WAIT_LAST) begin
                    // Watchdog abort: flag it and drop all working state.
                    alarm_d   = 1'b1;
                    pt_d      = '0;
                    kin_d     = '0;
                    sreg_d    = '0;
                    key_d     = '0;
                    srin_d    = '0;
                    ct_d      = '0;
                    wait_d    = '0;
                    cnt_clear = 1'b1;
                    state_d   = IDLE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            MIX: begin
                sreg_d = mix_val;
                key_d  = key_next;
                if (last_round) begin
                    ct_d    = mix_val;
                    state_d = DONE;
                end else begin
                    cnt_inc = 1'b1;
                    state_d = SUB_REQ;
                end
            end
            DONE: begin
                if (!start) begin
                    cnt_clear = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge int_osc) begin
        if (reset) begin
            state_q <= IDLE;
            pt_q    <= '0;
            kin_q   <= '0;
            sreg_q  <= '0;
            key_q   <= '0;
            srin_q  <= '0;
            ct_q    <= '0;
            alarm_q <= 1'b0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            pt_q    <= pt_d;
            kin_q   <= kin_d;
            sreg_q  <= sreg_d;
            key_q   <= key_d;
            srin_q  <= srin_d;
            ct_q    <= ct_d;
            alarm_q <= alarm_d;
            wait_q  <= wait_d;
        end
    end

    assign sb_start   = (state_q == SUB_REQ);
    assign sb_in      = sreg_q;
    assign sr_in      = srin_q;
    assign key_cur    = key_q;
    assign sreg       = sreg_q;
    assign busy       = active;
    assign done       = (state_q == DONE);
    assign alarm      = alarm_q;
    assign cyphertext = ct_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_round_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_aes_round_ctrl
// Brief   : Self-checking bench for aes_round_ctrl with behavioural AES units.
// Revision: 1.0 - initial release
// ============================================================================
module tb_aes_round_ctrl;
    import aes_pkg::*;

    localparam int SB_MAX_WAIT = 15;

    logic   int_osc = 1'b0;
    logic   reset;
    logic   start;
    block_t plaintext, key;
    logic   sb_start, sb_done, busy, done, alarm;
    block_t sb_in, sb_out, sr_in, sr_out, mc_out, key_cur, key_next, sreg, cyphertext;
    logic [7:0] rcon;
    logic [3:0] round;

    int n_chk = 0, n_pass = 0, n_fail = 0;

    always #5 int_osc = ~int_osc;

    // ---------------- behavioural AES primitives ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] p, inv;
        p   = a;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin   // a^254 is the field inverse
            p   = gmul(p, p);
            inv = gmul(inv, p);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic block_t sub_bytes(input block_t x);
        block_t o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(x[8*i +: 8]);
        return o;
    endfunction

    function automatic block_t shift_rows(input block_t x);
        block_t o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = x[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic block_t mix_cols(input block_t x);
        block_t o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = x[127-32*c -: 8];
            a1 = x[119-32*c -: 8];
            a2 = x[111-32*c -: 8];
            a3 = x[103-32*c -: 8];
            o[127-32*c -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
            o[103-32*c -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
        end
        return o;
    endfunction

    function automatic block_t key_exp(input block_t k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t = {w3[23:0], w3[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [7:0] exp_rcon(input int r);
        logic [7:0] rc;
        rc = 8'h01;
        if (r < 1 || r > 10) return 8'h00;
        for (int i = 1; i < r; i++) rc = gmul(rc, 8'h02);
        return rc;
    endfunction

    function automatic block_t aes_ref(input block_t pt, input block_t k);
        block_t s, rk;
        s  = pt ^ k;
        rk = k;
        for (int r = 1; r <= 10; r++) begin
            s  = shift_rows(sub_bytes(s));
            if (r < 10) s = mix_cols(s);
            rk = key_exp(rk, exp_rcon(r));
            s  = s ^ rk;
        end
        return s;
    endfunction

    // ---------------- datapath fixture ----------------
    assign sr_out   = shift_rows(sr_in);
    assign mc_out   = mix_cols(sr_out);
    assign key_next = key_exp(key_cur, rcon);

    int     sb_lat  = 1;
    bit     sb_hold = 1'b0;
    bit     spur_en = 1'b0;
    int     sb_cnt  = 0;
    logic   sb_done_m = 1'b0;
    logic   inj = 1'b0;
    block_t sb_res = '0;

    always @(posedge int_osc) begin
        sb_done_m <= 1'b0;
        if (sb_start && !sb_hold) begin
            sb_res <= sub_bytes(sb_in);
            if (sb_lat == 1) sb_done_m <= 1'b1;
            else             sb_cnt    <= sb_lat - 1;
        end else if (sb_cnt != 0) begin
            sb_cnt <= sb_cnt - 1;
            if (sb_cnt == 1) sb_done_m <= 1'b1;
        end
    end

    // Spurious done pulse while the controller is still in SUB_REQ.
    always @(negedge int_osc) inj <= spur_en && sb_start;

    assign sb_done = sb_done_m | inj;
    assign sb_out  = sb_res;

    aes_round_ctrl #(.SB_MAX_WAIT(SB_MAX_WAIT)) dut (
        .int_osc    (int_osc),
        .reset      (reset),
        .start      (start),
        .plaintext  (plaintext),
        .key        (key),
        .sb_start   (sb_start),
        .sb_in      (sb_in),
        .sb_done    (sb_done),
        .sb_out     (sb_out),
        .sr_in      (sr_in),
        .sr_out     (sr_out),
        .mc_out     (mc_out),
        .key_cur    (key_cur),
        .rcon       (rcon),
        .key_next   (key_next),
        .sreg       (sreg),
        .round      (round),
        .busy       (busy),
        .done       (done),
        .alarm      (alarm),
        .cyphertext (cyphertext)
    );

    // ---------------- checking ----------------
    task automatic chkw(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        chkw({tag, "_sreg"}, sreg, '0);
        chkw({tag, "_key_cur"}, key_cur, '0);
        chkw({tag, "_sr_in"}, sr_in, '0);
        chkw({tag, "_ct"}, cyphertext, '0);
        chkw({tag, "_round_rcon"}, 128'({round, rcon}), '0);
        chk1({tag, "_sb_start"}, sb_start, 1'b0);
        chk1({tag, "_busy"}, busy, 1'b0);
        chk1({tag, "_done"}, done, 1'b0);
        chk1({tag, "_alarm"}, alarm, 1'b0);
    endtask

    task automatic tick();
        @(posedge int_osc);
        @(negedge int_osc);
    endtask

    function automatic block_t rand_block();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic run_block(input block_t pt, input block_t k, input int lat,
                             input bit noisy, input bit hold, input string tag);
        int     edges, pulses;
        bit     extra;
        block_t exp;
        exp     = aes_ref(pt, k);
        sb_lat  = lat;
        spur_en = noisy;
        @(negedge int_osc);
        plaintext = pt;
        key       = k;
        start     = 1'b1;
        tick();
        plaintext = rand_block();
        key       = rand_block();
        if (!hold) start = 1'b0;
        chk1({tag, "_busy_init"}, busy, 1'b1);
        edges  = 0;
        pulses = 0;
        while (done !== 1'b1 && edges < 1000) begin
            tick();
            edges++;
            if (sb_start === 1'b1) begin
                pulses++;
                if (pulses == 1) chkw({tag, "_sreg_init"}, sreg, pt ^ k);
                chkw({tag, "_round_rcon"}, 128'({round, rcon}),
                     128'({4'(pulses), exp_rcon(pulses)}));
            end
            if (noisy && done !== 1'b1) start = 1'($urandom_range(0, 1));
        end
        chkw({tag, "_latency"}, 128'(edges), 128'(10 * (lat + 2) + 1));
        chkw({tag, "_sb_pulses"}, 128'(pulses), 128'(10));
        chkw({tag, "_ct"}, cyphertext, exp);
        chk1({tag, "_busy_done"}, busy, 1'b0);
        chkw({tag, "_rcon_done"}, 128'(rcon), '0);
        if (hold) begin
            extra = 1'b0;
            repeat (5) begin
                tick();
                if (sb_start === 1'b1) extra = 1'b1;
            end
            chk1({tag, "_hold_done"}, done, 1'b1);
            chk1({tag, "_hold_no_rerun"}, extra, 1'b0);
        end
        start   = 1'b0;
        spur_en = 1'b0;
        tick();
        chk1({tag, "_idle_done"}, done, 1'b0);
        chk1({tag, "_idle_busy"}, busy, 1'b0);
    endtask

    // ---------------- directed sequence ----------------
    localparam block_t KEY1 = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
    localparam block_t PT1  = 128'h6BC1BEE22E409F96E93D7E117393172A;
    localparam block_t PT2  = 128'h3243F6A8885A308D313198A2E0370734;

    initial begin : main
        int  pulses, edges;
        bit  seen;
        reset     = 1'b1;
        start     = 1'b0;
        plaintext = '0;
        key       = '0;
        repeat (2) @(posedge int_osc);
        @(negedge int_osc);
        reset = 1'b0;
        tick();
        check_reset("por");

        // Known-answer vectors, including the literal expected values.
        chkw("kat1_ref", aes_ref(PT1, KEY1), 128'h3AD77BB40D7A3660A89ECAF32466EF97);
        chkw("kat1_xor", PT1 ^ KEY1, 128'h40BFABF406EE4D3042CA6B997A5C5816);
        run_block(PT1, KEY1, 1, 1'b0, 1'b0, "kat1");
        chkw("kat1_ct_lit", cyphertext, 128'h3AD77BB40D7A3660A89ECAF32466EF97);
        run_block(PT2, KEY1, 4, 1'b0, 1'b0, "kat2");
        chkw("kat2_ct_lit", cyphertext, 128'h3925841D02DC09FBDC118597196A0B32);

        // Start held through DONE, then a fresh run.
        run_block(PT2, KEY1, 2, 1'b0, 1'b1, "hold");
        run_block(PT2, KEY1, 2, 1'b0, 1'b0, "rerun");
        chkw("rerun_ct_lit", cyphertext, 128'h3925841D02DC09FBDC118597196A0B32);

        // Reset during round 5 with a SubBytes result still in flight.
        sb_lat    = 3;
        plaintext = rand_block();
        key       = rand_block();
        start     = 1'b1;
        tick();
        start  = 1'b0;
        pulses = 0;
        edges  = 0;
        while (pulses < 5 && edges < 500) begin
            tick();
            edges++;
            if (sb_start === 1'b1) pulses++;
        end
        chkw("rst5_round", 128'(round), 128'(5));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset("rst5");
        repeat (6) tick();
        chk1("rst5_late_busy", busy, 1'b0);
        chkw("rst5_late_sr_in", sr_in, '0);
        chkw("rst5_late_sreg", sreg, '0);
        run_block(rand_block(), rand_block(), 2, 1'b0, 1'b0, "post_rst");

        // Watchdog: SubBytes never answers.
        sb_hold   = 1'b1;
        plaintext = rand_block();
        key       = rand_block();
        start     = 1'b1;
        tick();
        start = 1'b0;
        seen  = 1'b0;
        edges = 0;
        while (!seen && edges < 20) begin
            tick();
            edges++;
            if (sb_start === 1'b1) seen = 1'b1;
        end
        chk1("wd_sb_start_seen", seen, 1'b1);
        repeat (SB_MAX_WAIT) @(posedge int_osc);
        @(negedge int_osc);
        chk1("wd_alarm_early", alarm, 1'b0);
        chk1("wd_busy_early", busy, 1'b1);
        tick();
        chk1("wd_alarm", alarm, 1'b1);
        chk1("wd_busy", busy, 1'b0);
        chkw("wd_round", 128'(round), '0);
        chkw("wd_sreg", sreg, '0);
        sb_hold = 1'b0;
        run_block(rand_block(), rand_block(), 3, 1'b0, 1'b0, "wd_after");
        chk1("wd_sticky", alarm, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk1("wd_cleared", alarm, 1'b0);

        // Spurious sb_done in SUB_REQ and start noise mid-run.
        run_block(PT1, KEY1, 2, 1'b1, 1'b0, "spur");
        chkw("spur_ct_lit", cyphertext, 128'h3AD77BB40D7A3660A89ECAF32466EF97);

        // Random blocks and latencies.
        for (int i = 0; i < 6; i++) begin
            run_block(rand_block(), rand_block(), int'($urandom_range(1, 5)),
                      1'($urandom_range(0, 1)), 1'b0, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
